// File: rtl/prog_updown_counter.sv
// prog_updown_counter: loadable up/down counter with programmable limit, wrap or saturate
module prog_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);
    logic [WIDTH-1:0] count_nxt;
    logic             ovf_nxt;

    assign tc = up_dn ? (count == max_val) : (count == '0);

    // next count: load beats enable; out-of-range counts clamp to the limit before any step
    always_comb begin
        count_nxt = count;
        ovf_nxt   = 1'b0;
        if (load) begin
            count_nxt = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            if (count > max_val) begin
                count_nxt = max_val;
            end else if (tc) begin
                ovf_nxt   = 1'b1;
                count_nxt = (SATURATE != 0) ? count : (up_dn ? '0 : max_val);
            end else begin
                count_nxt = up_dn ? count + WIDTH'(1) : count - WIDTH'(1);
            end
        end
    end

    // state register with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end
endmodule

// File: tb/tb_prog_updown_counter.sv
// tb_prog_updown_counter: directed bench comparing wrap and saturate counters to an integer model
module tb_prog_updown_counter;
    logic       clk = 1'b0;
    logic       rst;
    logic       en, up_dn, load;
    logic [3:0] load_val, max_val;
    logic [3:0] count0, count1;
    logic       tc0, tc1, ovf0, ovf1;
    int         compared = 0;
    int         mismatched = 0;
    int         m_cnt [2] = '{0, 0};
    int         m_ovf [2] = '{0, 0};

    prog_updown_counter #(.WIDTH(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .max_val(max_val), .count(count0), .tc(tc0), .ovf(ovf0)
    );
    prog_updown_counter #(.WIDTH(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .max_val(max_val), .count(count1), .tc(tc1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int model_tc(input int c);
        return up_dn ? int'(c == int'(max_val)) : int'(c == 0);
    endfunction

    // reference behaviour in plain integers: index 0 wraps, index 1 saturates
    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            int c, mx;
            c  = m_cnt[i];
            mx = int'(max_val);
            if (!rst) begin
                m_cnt[i] <= 0;
                m_ovf[i] <= 0;
            end else if (load) begin
                m_cnt[i] <= (int'(load_val) < mx) ? int'(load_val) : mx;
                m_ovf[i] <= 0;
            end else if (!en) begin
                m_ovf[i] <= 0;
            end else if (c > mx) begin
                m_cnt[i] <= mx;
                m_ovf[i] <= 0;
            end else if (up_dn && c == mx) begin
                m_cnt[i] <= (i == 1) ? mx : 0;
                m_ovf[i] <= 1;
            end else if (!up_dn && c == 0) begin
                m_cnt[i] <= (i == 1) ? 0 : mx;
                m_ovf[i] <= 1;
            end else begin
                m_cnt[i] <= up_dn ? c + 1 : c - 1;
                m_ovf[i] <= 0;
            end
        end
    end

    // every-cycle comparison away from the active edge
    always @(negedge clk) begin
        chk("wrap_count", int'(count0), m_cnt[0]);
        chk("wrap_ovf", int'(ovf0), m_ovf[0]);
        chk("wrap_tc", int'(tc0), model_tc(m_cnt[0]));
        chk("sat_count", int'(count1), m_cnt[1]);
        chk("sat_ovf", int'(ovf1), m_ovf[1]);
        chk("sat_tc", int'(tc1), model_tc(m_cnt[1]));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; up_dn = 1'b0; load = 1'b0; load_val = 4'd0; max_val = 4'd15;
        #20 rst = 1'b1;
        // count down from 0 wraps to 15
        step(1);
        chk("lit_down_wrap", int'(count0), 15);
        chk("lit_down_wrap_ovf", int'(ovf0), 1);
        chk("lit_down_sat_hold", int'(count1), 0);
        step(15);
        chk("lit_down_zero", int'(count0), 0);
        chk("lit_down_zero_tc", int'(tc0), 1);
        step(1);
        chk("lit_down_rewrap", int'(count0), 15);
        // up count to 9 and wrap
        load = 1'b1; load_val = 4'd0; max_val = 4'd9; up_dn = 1'b1;
        step(1);
        load = 1'b0;
        step(9);
        chk("lit_up_nine", int'(count0), 9);
        chk("lit_up_nine_tc", int'(tc0), 1);
        step(1);
        chk("lit_up_wrap", int'(count0), 0);
        chk("lit_up_wrap_ovf", int'(ovf0), 1);
        step(1);
        chk("lit_up_one", int'(count0), 1);
        chk("lit_up_one_ovf", int'(ovf0), 0);
        // saturate at 5 then count back down to 0
        load = 1'b1; load_val = 4'd0; max_val = 4'd5;
        step(1);
        load = 1'b0;
        step(8);
        chk("lit_sat_hold5", int'(count1), 5);
        chk("lit_sat_ovf5", int'(ovf1), 1);
        up_dn = 1'b0;
        step(1);
        chk("lit_sat_dn4", int'(count1), 4);
        chk("lit_sat_dn4_ovf", int'(ovf1), 0);
        step(5);
        chk("lit_sat_hold0", int'(count1), 0);
        chk("lit_sat_ovf0", int'(ovf1), 1);
        // load clamps to max_val and wins over enable
        en = 1'b0; load = 1'b1; load_val = 4'd12; max_val = 4'd9;
        step(1);
        chk("lit_load_clamp", int'(count0), 9);
        load_val = 4'd3; en = 1'b1; up_dn = 1'b1;
        step(1);
        chk("lit_load_wins", int'(count0), 3);
        load = 1'b0;
        step(1);
        chk("lit_after_load", int'(count0), 4);
        // lowered limit clamps, zero limit holds ovf high
        load = 1'b1; load_val = 4'd8; max_val = 4'd15;
        step(1);
        load = 1'b0; max_val = 4'd4;
        step(1);
        chk("lit_clamp4", int'(count0), 4);
        chk("lit_clamp4_ovf", int'(ovf0), 0);
        max_val = 4'd0;
        step(2);
        chk("lit_max0_count", int'(count0), 0);
        chk("lit_max0_ovf", int'(ovf0), 1);
        up_dn = 1'b0;
        step(2);
        chk("lit_max0_dn_ovf", int'(ovf1), 1);
        // asynchronous reset mid-count
        load = 1'b1; load_val = 4'd0; max_val = 4'd15; up_dn = 1'b1;
        step(1);
        load = 1'b0;
        step(7);
        chk("lit_pre_rst7", int'(count0), 7);
        #1 rst = 1'b0;
        #1;
        chk("lit_async_count", int'(count0), 0);
        chk("lit_async_ovf", int'(ovf0), 0);
        #10 rst = 1'b1;
        step(1);
        chk("lit_resume", int'(count0), 1);
        // reset asserted during a load
        load = 1'b1; load_val = 4'd6;
        #1 rst = 1'b0;
        step(1);
        chk("lit_rst_over_load", int'(count0), 0);
        rst = 1'b1;
        step(1);
        chk("lit_load_after_rst", int'(count0), 6);
        load = 1'b0;
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/prog_updown_counter.md
PROG_UPDOWN_COUNTER -- requirements
Module: prog_updown_counter

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 4, counter width in bits (legal range 2..32).
REQ-002 The block SHALL provide parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1, count enable.
REQ-006 The block SHALL have port up_dn, input, 1, direction: 1 = up, 0 = down.
REQ-007 The block SHALL have port load, input, 1, synchronous load strobe.
REQ-008 The block SHALL have port load_val, input, WIDTH, value to load.
REQ-009 The block SHALL have port max_val, input, WIDTH, programmable upper limit (inclusive).
REQ-010 The block SHALL have port count, output, WIDTH, registered count value.
REQ-011 The block SHALL have port tc, output, 1, combinational terminal-count flag.
REQ-012 The block SHALL have port ovf, output, 1, registered one-cycle limit-event pulse.

Function
REQ-013 Priority SHALL be rst > load > en; with en=0 and load=0, count and ovf SHALL go to/hold: count holds, ovf=0.
REQ-014 load=1 SHALL set count to min(load_val, max_val) on the next edge, regardless of en and up_dn; ovf=0 that cycle.
REQ-015 en=1, up_dn=1, count<max_val: count SHALL increment by 1 per edge.
REQ-016 en=1, up_dn=1, count==max_val: count SHALL become 0 (SATURATE=0) or hold max_val (SATURATE=1).
REQ-017 en=1, up_dn=0, 0<count<=max_val: count SHALL decrement by 1 per edge.
REQ-018 en=1, up_dn=0, count==0: count SHALL become max_val (SATURATE=0) or hold 0 (SATURATE=1).
REQ-019 en=1 with count>max_val (max_val lowered mid-run) SHALL set count to max_val on the next edge in either direction; ovf=0.
REQ-020 tc SHALL be 1 when (up_dn=1 and count==max_val) or (up_dn=0 and count==0), else 0; no clock latency.
REQ-021 ovf SHALL be 1 for exactly the one cycle following any enabled edge taken while tc=1 (wrap or blocked saturate step), else 0.
REQ-022 max_val==0: count SHALL remain 0; every enabled edge is a limit event and ovf SHALL stay 1 while en=1.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH unsigned; no X or out-of-range count SHALL appear for any input sequence.
REQ-024 up_dn changes SHALL take effect on the next enabled edge with no lost or duplicated step.

Reset
REQ-025 rst=0 SHALL force count=0 and ovf=0 immediately, independent of clk, including mid-count and during load.
REQ-026 While rst=0 all inputs SHALL be ignored; first update occurs on the first rising clk edge after rst deasserts.

Verification
REQ-027 WIDTH=4, max_val=15, SATURATE=0, en=1, up_dn=0, rst low 20 ns then high (10 ns clock) -> count 0,15,14,...,0,15; ovf pulses after each 0->15 step; tc=1 whenever count=0.
REQ-028 WIDTH=4, max_val=9, up_dn=1, en=1 -> count 0..9,0,1; ovf high one cycle after 9->0; tc=1 at count=9.
REQ-029 SATURATE=1, max_val=5, up_dn=1, en=1 for 8 edges -> count 0..5 then holds 5; ovf=1 for each cycle after a blocked step; switch up_dn=0 -> 4,3,...,0, holds 0.
REQ-030 load=1, load_val=12, max_val=9, en=0 -> count=9 next edge; load_val=3 with en=1, up_dn=1 -> count=3 (load wins), then 4.
REQ-031 count=8, max_val lowered to 4, en=1 -> count=4 next edge, ovf=0; max_val=0 -> count=0, ovf held 1 while en=1.
REQ-032 Assert rst=0 asynchronously between edges at count=7 -> count=0, ovf=0 before next edge; release -> counting resumes from 0.
